fft_output_demix: RTL and testbench

Write-back side of the radix-4 datapath. Accepts four complex butterfly results per word together with the lane-rotation code that was used when those operands were read from the bank memories. Undoes that rotation so lane k returns to bank k, and buffers results in a 2-entry FIFO with valid/ready handshakes on both sides. Tags each word with its in-stage index and flags the last word of an FFT stage.

---
 rtl/fft_output_demix.sv | 147 ++++++++++++++
 tb/tb_fft_output_demix.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_demix.sv
// fft_output_demix
// Write-back side of the radix-4 datapath. Each incoming word carries four
// complex butterfly results in rotated lane order. The rotation is undone on
// push, so that bank k again holds lane (k - iSEL) mod 4. Words pass through a
// 2-entry FIFO with valid/ready on both sides. Each entry carries its in-stage
// index, and the block flags and pulses the end of each FFT stage.
module fft_output_demix #(
    parameter int BIT     = 17,
    parameter int N_WORDS = 256,
    parameter int CNT_W   = 8
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iCLR,
    input  logic             iVALID,
    output logic             oREADY,
    input  logic [1:0]       iSEL,
    input  logic [BIT-1:0]   iX0_RE,
    input  logic [BIT-1:0]   iX0_IM,
    input  logic [BIT-1:0]   iX1_RE,
    input  logic [BIT-1:0]   iX1_IM,
    input  logic [BIT-1:0]   iX2_RE,
    input  logic [BIT-1:0]   iX2_IM,
    input  logic [BIT-1:0]   iX3_RE,
    input  logic [BIT-1:0]   iX3_IM,
    output logic             oVALID,
    input  logic             iREADY,
    output logic [BIT-1:0]   oY0_RE,
    output logic [BIT-1:0]   oY0_IM,
    output logic [BIT-1:0]   oY1_RE,
    output logic [BIT-1:0]   oY1_IM,
    output logic [BIT-1:0]   oY2_RE,
    output logic [BIT-1:0]   oY2_IM,
    output logic [BIT-1:0]   oY3_RE,
    output logic [BIT-1:0]   oY3_IM,
    output logic [CNT_W-1:0] oADDR,
    output logic             oLAST,
    output logic             oDONE
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

    logic [BIT-1:0]   xRe [4];
    logic [BIT-1:0]   xIm [4];
    logic [BIT-1:0]   rotRe [4];
    logic [BIT-1:0]   rotIm [4];

    logic [BIT-1:0]   memRe   [2][4];
    logic [BIT-1:0]   memIm   [2][4];
    logic [CNT_W-1:0] memAddr [2];

    logic             wrPtr;
    logic             rdPtr;
    logic [1:0]       count;
    logic [CNT_W-1:0] wcnt;
    logic             doneReg;

    logic             push;
    logic             pop;

    assign xRe[0] = iX0_RE;
    assign xRe[1] = iX1_RE;
    assign xRe[2] = iX2_RE;
    assign xRe[3] = iX3_RE;
    assign xIm[0] = iX0_IM;
    assign xIm[1] = iX1_IM;
    assign xIm[2] = iX2_IM;
    assign xIm[3] = iX3_IM;

    // Inverse of the read-side left rotation: bank k takes lane (k - iSEL) mod 4.
    // The 2-bit subtraction wraps naturally, giving the mod-4 index.
    for (genvar k = 0; k < 4; k++) begin : gRot
        localparam logic [1:0] K = 2'(k);
        assign rotRe[k] = xRe[K - iSEL];
        assign rotIm[k] = xIm[K - iSEL];
    end

    // oREADY comes only from the registered count, so a full FIFO cannot
    // accept a word in the same cycle that it pops one.
    assign oREADY = (count != 2'd2);
    assign oVALID = (count != 2'd0);
    assign push   = iVALID && oREADY;
    assign pop    = oVALID && iREADY;

    // Pointers, occupancy, write index and stage-done pulse.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            wrPtr   <= 1'b0;
            rdPtr   <= 1'b0;
            count   <= 2'd0;
            wcnt    <= '0;
            doneReg <= 1'b0;
        end else if (iCLR) begin
            wrPtr   <= 1'b0;
            rdPtr   <= 1'b0;
            count   <= 2'd0;
            wcnt    <= '0;
            doneReg <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= ~wrPtr;
                wcnt  <= (wcnt == LAST_IDX) ? '0 : wcnt + 1'b1;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            doneReg <= pop && oLAST;
        end
    end

    // Entry storage; the de-rotated word and its index are captured on push.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int e = 0; e < 2; e++) begin
                for (int b = 0; b < 4; b++) begin
                    memRe[e][b] <= '0;
                    memIm[e][b] <= '0;
                end
                memAddr[e] <= '0;
            end
        end else if (!iCLR && push) begin
            for (int b = 0; b < 4; b++) begin
                memRe[wrPtr][b] <= rotRe[b];
                memIm[wrPtr][b] <= rotIm[b];
            end
            memAddr[wrPtr] <= wcnt;
        end
    end

    assign oY0_RE = memRe[rdPtr][0];
    assign oY0_IM = memIm[rdPtr][0];
    assign oY1_RE = memRe[rdPtr][1];
    assign oY1_IM = memIm[rdPtr][1];
    assign oY2_RE = memRe[rdPtr][2];
    assign oY2_IM = memIm[rdPtr][2];
    assign oY3_RE = memRe[rdPtr][3];
    assign oY3_IM = memIm[rdPtr][3];
    assign oADDR  = memAddr[rdPtr];
    assign oLAST  = oVALID && (oADDR == LAST_IDX);
    assign oDONE  = doneReg;

endmodule

// File: tb/tb_fft_output_demix.sv
// Self-checking bench for fft_output_demix, built with a 4-word stage so that
// index wrap and stage boundaries show up quickly.
module tb_fft_output_demix;

    localparam int BIT = 17;
    localparam int NW  = 4;
    localparam int CW  = 3;

    logic          iCLK = 1'b0;
    logic          iRESET;
    logic          iCLR;
    logic          iVALID;
    logic          oREADY;
    logic [1:0]    iSEL;
    logic [BIT-1:0] iX0_RE, iX0_IM, iX1_RE, iX1_IM;
    logic [BIT-1:0] iX2_RE, iX2_IM, iX3_RE, iX3_IM;
    logic          oVALID;
    logic          iREADY;
    logic [BIT-1:0] oY0_RE, oY0_IM, oY1_RE, oY1_IM;
    logic [BIT-1:0] oY2_RE, oY2_IM, oY3_RE, oY3_IM;
    logic [CW-1:0] oADDR;
    logic          oLAST;
    logic          oDONE;

    fft_output_demix #(.BIT(BIT), .N_WORDS(NW), .CNT_W(CW)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iCLR(iCLR),
        .iVALID(iVALID), .oREADY(oREADY), .iSEL(iSEL),
        .iX0_RE(iX0_RE), .iX0_IM(iX0_IM), .iX1_RE(iX1_RE), .iX1_IM(iX1_IM),
        .iX2_RE(iX2_RE), .iX2_IM(iX2_IM), .iX3_RE(iX3_RE), .iX3_IM(iX3_IM),
        .oVALID(oVALID), .iREADY(iREADY),
        .oY0_RE(oY0_RE), .oY0_IM(oY0_IM), .oY1_RE(oY1_RE), .oY1_IM(oY1_IM),
        .oY2_RE(oY2_RE), .oY2_IM(oY2_IM), .oY3_RE(oY3_RE), .oY3_IM(oY3_IM),
        .oADDR(oADDR), .oLAST(oLAST), .oDONE(oDONE)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]     sel;
        logic [BIT-1:0] xr [4];
        logic [BIT-1:0] er [4];
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkD(input string name, input logic [BIT-1:0] act, input logic [BIT-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%05h expected 0x%05h", name, act, exp);
        end
    endtask

    task automatic setVec(input int i, input logic [1:0] s,
                          input int a0, input int a1, input int a2, input int a3,
                          input int e0, input int e1, input int e2, input int e3);
        vecs[i].sel   = s;
        vecs[i].xr[0] = BIT'(a0);
        vecs[i].xr[1] = BIT'(a1);
        vecs[i].xr[2] = BIT'(a2);
        vecs[i].xr[3] = BIT'(a3);
        vecs[i].er[0] = BIT'(e0);
        vecs[i].er[1] = BIT'(e1);
        vecs[i].er[2] = BIT'(e2);
        vecs[i].er[3] = BIT'(e3);
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    // Lane k carries re = m+k, im = -(m+k); rotation code 0.
    task automatic driveMark(input int m);
        iSEL   = 2'd0;
        iX0_RE = BIT'(m);     iX0_IM = BIT'(-m);
        iX1_RE = BIT'(m + 1); iX1_IM = BIT'(-(m + 1));
        iX2_RE = BIT'(m + 2); iX2_IM = BIT'(-(m + 2));
        iX3_RE = BIT'(m + 3); iX3_IM = BIT'(-(m + 3));
    endtask

    task automatic checkMark(input string tag, input int m, input int addr);
        chk({tag, "_valid"}, oVALID, 1);
        chkD({tag, "_y0re"}, oY0_RE, BIT'(m));
        chkD({tag, "_y3im"}, oY3_IM, BIT'(-(m + 3)));
        chk({tag, "_addr"}, oADDR, addr);
    endtask

    initial begin
        int expW;
        int prevAddr;
        int doneCnt;

        iRESET = 1'b0; iCLR = 1'b0; iVALID = 1'b0; iREADY = 1'b0;
        driveMark(0);

        // Reset state
        #2;
        chk("rst_valid", oVALID, 0);
        chk("rst_ready", oREADY, 1);
        chkD("rst_y0re", oY0_RE, '0);
        chkD("rst_y3im", oY3_IM, '0);
        chk("rst_addr", oADDR, 0);
        chk("rst_last", oLAST, 0);
        chk("rst_done", oDONE, 0);
        #10 iRESET = 1'b1;
        step();

        // Rotation table: lane values and the hand-derived bank order
        setVec(0, 2'd0, 1, 2, 3, 4,        1, 2, 3, 4);
        setVec(1, 2'd1, 1, 2, 3, 4,        4, 1, 2, 3);
        setVec(2, 2'd2, 1, 2, 3, 4,        3, 4, 1, 2);
        setVec(3, 2'd3, 1, 2, 3, 4,        2, 3, 4, 1);
        setVec(4, 2'd2, 65535, -65535, 0, 7,   0, 7, 65535, -65535);
        setVec(5, 2'd1, 10, 20, 30, 40,    40, 10, 20, 30);

        expW = 0;
        iREADY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            iSEL   = vecs[i].sel;
            iX0_RE = vecs[i].xr[0]; iX0_IM = -vecs[i].xr[0];
            iX1_RE = vecs[i].xr[1]; iX1_IM = -vecs[i].xr[1];
            iX2_RE = vecs[i].xr[2]; iX2_IM = -vecs[i].xr[2];
            iX3_RE = vecs[i].xr[3]; iX3_IM = -vecs[i].xr[3];
            iVALID = 1'b1;
            step();
            iVALID = 1'b0;
            chk("rot_valid", oVALID, 1);
            chkD("rot_y0re", oY0_RE, vecs[i].er[0]);
            chkD("rot_y1re", oY1_RE, vecs[i].er[1]);
            chkD("rot_y2re", oY2_RE, vecs[i].er[2]);
            chkD("rot_y3re", oY3_RE, vecs[i].er[3]);
            chkD("rot_y0im", oY0_IM, -vecs[i].er[0]);
            chkD("rot_y1im", oY1_IM, -vecs[i].er[1]);
            chkD("rot_y2im", oY2_IM, -vecs[i].er[2]);
            chkD("rot_y3im", oY3_IM, -vecs[i].er[3]);
            chk("rot_addr", oADDR, expW % NW);
            chk("rot_last", oLAST, (expW % NW) == NW - 1);
            step();
            chk("rot_popped", oVALID, 0);
            chk("rot_done", oDONE, (expW % NW) == NW - 1);
            expW++;
        end

        // Clear an idle FIFO; index must restart at 0
        iCLR = 1'b1;
        step();
        iCLR = 1'b0;

        // Backpressure: third word must be held off until space frees up
        iREADY = 1'b0;
        driveMark(10); iVALID = 1'b1;
        step();
        chk("bp_ready1", oREADY, 1);
        checkMark("bp_head1", 10, 0);
        driveMark(20);
        step();
        chk("bp_ready2", oREADY, 0);
        checkMark("bp_head2", 10, 0);
        driveMark(30);
        step();
        chk("bp_ready3", oREADY, 0);
        checkMark("bp_hold", 10, 0);
        iREADY = 1'b1;
        step();
        chk("bp_ready4", oREADY, 1);
        checkMark("bp_pop1", 20, 1);
        step();
        iVALID = 1'b0;
        checkMark("bp_pop2", 30, 2);
        step();
        chk("bp_empty", oVALID, 0);
        chk("bp_done", oDONE, 0);

        // Stage boundary: five back-to-back words
        iCLR = 1'b1;
        step();
        iCLR = 1'b0;
        doneCnt = 0;
        iVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            driveMark(100 + 10 * i);
            step();
            checkMark("stg_head", 100 + 10 * i, i % NW);
            chk("stg_last", oLAST, i == 3);
            chk("stg_done", oDONE, i == 4);
            doneCnt += int'(oDONE);
        end
        iVALID = 1'b0;
        step();
        chk("stg_empty", oVALID, 0);
        chk("stg_done_end", oDONE, 0);
        doneCnt += int'(oDONE);
        chk("stg_done_count", doneCnt, 1);

        // Simultaneous push/pop holding one entry; write index is now 1
        iREADY = 1'b0;
        driveMark(200); iVALID = 1'b1;
        step();
        prevAddr = 1;
        iREADY = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            driveMark(200 + j);
            step();
            checkMark("pp_head", 200 + j, (1 + j) % NW);
            chk("pp_ready", oREADY, 1);
            chk("pp_done", oDONE, prevAddr == NW - 1);
            prevAddr = (1 + j) % NW;
        end
        iVALID = 1'b0;
        step();
        chk("pp_empty", oVALID, 0);
        chk("pp_done_end", oDONE, prevAddr == NW - 1);

        // Clear while full with a word offered
        iREADY = 1'b0;
        driveMark(300); iVALID = 1'b1;
        step();
        driveMark(310);
        step();
        chk("clr_full", oREADY, 0);
        iCLR = 1'b1;
        driveMark(320);
        step();
        chk("clr_valid", oVALID, 0);
        chk("clr_ready", oREADY, 1);
        chk("clr_done", oDONE, 0);
        iCLR = 1'b0; iVALID = 1'b0;
        step();
        chk("clr_dropped", oVALID, 0);
        driveMark(330); iVALID = 1'b1;
        step();
        iVALID = 1'b0;
        checkMark("clr_next", 330, 0);
        iREADY = 1'b1;
        step();

        // Async reset between edges with two words buffered
        iREADY = 1'b0;
        driveMark(400); iVALID = 1'b1;
        step();
        driveMark(410);
        step();
        iVALID = 1'b0;
        checkMark("ar_pre", 400, 1);
        #3 iRESET = 1'b0;
        #1;
        chk("ar_valid", oVALID, 0);
        chk("ar_ready", oREADY, 1);
        chkD("ar_y0re", oY0_RE, '0);
        chkD("ar_y3im", oY3_IM, '0);
        chk("ar_addr", oADDR, 0);
        chk("ar_last", oLAST, 0);
        chk("ar_done", oDONE, 0);
        #2 iRESET = 1'b1;
        #1;
        driveMark(420); iVALID = 1'b1;
        step();
        iVALID = 1'b0;
        checkMark("ar_after", 420, 0);
        iREADY = 1'b1;
        step();
        chk("ar_empty", oVALID, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
